// File: rtl/clk_div_ctrl.sv
// Run/stop and reconfiguration controller for the half-period clock divider.
// Outputs are registered; cfg_ready comes straight from the pending flag.
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_div
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIV_RST = DEFAULT_DIV[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic xfer, div_ok, wrap, apply;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= ONE;
      cur_div_q  <= DIV_RST;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    clk_div_d  = clk_div_q;
    tick_d     = 1'b0;
    apply      = 1'b0;
    xfer       = cfg_valid && !pend_q;
    div_ok     = |cfg_div;
    wrap       = (cnt_q == cur_div_q);
    cfg_err_d  = xfer && !div_ok;

    case (state_q)
      S_IDLE: begin
        clk_div_d = 1'b0;
        cnt_d     = ONE;
        if (xfer && div_ok) cur_div_d = cfg_div;
        if (run) state_d = S_RUN;
      end
      default: begin
        if (state_q == S_RUN && !run && !clk_div_q) begin
          // Stop during a low phase: truncating low is harmless.
          state_d = S_IDLE;
          cnt_d   = ONE;
        end else if (wrap) begin
          cnt_d     = ONE;
          clk_div_d = !clk_div_q;
          tick_d    = 1'b1;
          if (clk_div_q) state_d = run ? S_RUN : S_IDLE;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = run ? S_RUN : S_STOP;
        end

        apply = (state_d == S_IDLE) || (wrap && clk_div_q);
        if (apply && pend_q) begin
          cur_div_d = pend_div_q;
          pend_d    = 1'b0;
        end
        // Once headed for IDLE there is no boundary to wait for.
        if (xfer && div_ok) begin
          if (state_d == S_IDLE) begin
            cur_div_d = cfg_div;
          end else begin
            pend_div_d = cfg_div;
            pend_d     = 1'b1;
          end
        end
      end
    endcase
  end

  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign clk_div   = clk_div_q;
  assign tick      = tick_q;
  assign running   = (state_q != S_IDLE);
  assign cur_div   = cur_div_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run/stop and reconfiguration controller for the team's half-period clock divider. Owns the active divisor, starts and stops the divided output only at glitch-free boundaries, and accepts new divisors through a valid/ready handshake that takes effect at the next falling edge of the divided clock. Sits between the configuration/control logic and any logic clocked or enabled by the divided output.

## Interface
- WIDTH, 8: width of divisor and phase counter; legal divisors 1..2^WIDTH-1.
- DEFAULT_DIV, 2: divisor loaded on reset; must be 1..2^WIDTH-1.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = produce divided clock, 0 = stop request.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  WIDTH  offered divisor (half-period in clk cycles).
- cfg_ready  out  1  controller can accept a divisor this cycle.
- cfg_err  out  1  one-cycle pulse: offered divisor was 0 and was dropped.
- clk_div  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse in the cycle clk_div shows a new value.
- running  out  1  state != IDLE.
- cur_div  out  WIDTH  active divisor.

## Operation
- States: IDLE, RUN, STOPPING.
- Phase counter cnt, 1..cur_div. In RUN/STOPPING, each cycle: if cnt == cur_div then cnt <= 1, clk_div toggles, tick <= 1; else cnt <= cnt + 1. cnt never exceeds cur_div (cur_div changes only while cnt is reloaded to 1).
- Each phase lasts exactly cur_div cycles; period 2*cur_div. cur_div = 1 gives clk/2.
- IDLE: clk_div = 0, cnt = 1, tick = 0. run = 1 -> RUN next cycle.
- RUN: run = 0 with clk_div = 0 -> IDLE next cycle, cnt <= 1 (low phase may be truncated; never a short high phase). run = 0 with clk_div = 1 -> STOPPING.
- STOPPING: counting continues; on the 1->0 toggle -> IDLE, cnt <= 1. run = 1 again before that -> RUN, no disturbance to counting.
- Falling boundary = cycle in which clk_div toggles 1->0.
- Config handshake: transfer when cfg_valid && cfg_ready. cfg_ready = !pend.
  - cfg_div == 0: dropped; cfg_err = 1 next cycle; no other state changes.
  - IDLE: cur_div <= cfg_div next cycle; pend stays 0.
  - RUN/STOPPING: pend_div <= cfg_div, pend <= 1. At the next falling boundary: cur_div <= pend_div, pend <= 0, cnt <= 1; the following low phase already uses the new divisor.
- Falling boundary with both pend and a stop: both take effect; IDLE with new cur_div.
- Entering IDLE with pend set by any path (immediate low-phase stop) applies pend_div in the same cycle.
- Reset values: state IDLE, cnt 1, cur_div DEFAULT_DIV, pend 0, clk_div 0, tick 0, cfg_ready 1, cfg_err 0, running 0. Reset overrides run, cfg_valid and any in-flight phase.

## Timing
- run sampled high at edge E0 in IDLE: running = 1 after E0; first rise of clk_div after edge E0+cur_div; tick high for the cycle after that edge.
- Divisor accepted in IDLE: visible on cur_div 1 cycle after the transfer edge.
- Divisor accepted while running: cfg_ready low from the cycle after transfer until the cycle after the falling boundary.
- cfg_err: exactly 1 cycle, 1 cycle after the transfer edge.
- Stop with clk_div = 0: running = 0 one cycle after run sampled low. Stop with clk_div = 1: running = 0 in the cycle after the falling boundary.
- Outputs are registers; no combinational path from inputs to outputs except cfg_ready (from the pend register only).

## Test plan
- Reset, DEFAULT_DIV = 2, run = 1 -> clk_div rises 2 cycles after RUN entry; period 4 clk; tick on every toggle; cur_div = 2.
- Running at div 2, offer cfg_div = 5 during a high phase -> cfg_ready low until the falling boundary; the current high phase stays 2 cycles; the next low phase is 5 cycles; then period 10.
- Offer cfg_div = 0 -> cfg_err one-cycle pulse; cur_div and clk_div unchanged; cfg_ready stays 1.
- Drop run during the 2nd cycle of a 4-cycle high phase (div 4) -> high phase completes all 4 cycles, clk_div falls, running = 0 next. Drop run during a low phase -> IDLE next cycle with clk_div = 0.
- Assert reset mid-high-phase with a pending divisor -> next cycle clk_div = 0, cur_div = DEFAULT_DIV, cfg_ready = 1, running = 0; the pending divisor is discarded.
- WIDTH = 8: cfg_div = 1 -> clk_div toggles every cycle. cfg_div = 255 -> 255-cycle phases with no counter wrap. Simultaneous stop and pending update -> IDLE with the new cur_div.
